simple_dual_port_mem: RTL and testbench

SIMPLE_DUAL_PORT_MEM -- requirements
Module: simple_dual_port_mem

---
 rtl/simple_dual_port_mem.sv | 87 ++++++++
 tb/tb_simple_dual_port_mem.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/simple_dual_port_mem.sv
// Purpose : simple dual-port RAM, one write port and one registered read port on a single clock.
// Latency : 1 cycle from ra to q, every cycle (no read enable).
// Backpr. : none; a write or read is accepted on every rising edge while reset is high.
//
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous active-low reset; clears q only, never the array
//   ra    - read address (AW bits); ra >= MEM_SIZE reads back zero
//   wa    - write address (AW bits); wa >= MEM_SIZE drops the write
//   d     - write data
//   write - write enable, active high
//   q     - registered read data
//
// Build option: define SDPM_WRITE_FIRST_EN to make a same-address read-during-write
// return the incoming d (write-first). Left undefined, the read returns the old
// word (read-first) and the new word is visible on the following read.
module simple_dual_port_mem #(
    parameter int MEM_SIZE   = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int AW         = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         ra,
    input  logic [AW-1:0]         wa,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  write,
    output logic [DATA_WIDTH-1:0] q
);

    // One extra bit so MEM_SIZE itself is representable when it is a power of two.
    localparam logic [AW:0] MEM_LIMIT = MEM_SIZE[AW:0];

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    logic ra_ok;
    logic wa_ok;
    logic wr_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] q_next;

    // Non-power-of-two sizes leave a hole at the top of the address space;
    // accesses there must not alias onto real words.
    assign ra_ok = ({1'b0, ra} < MEM_LIMIT);
    assign wa_ok = ({1'b0, wa} < MEM_LIMIT);

    // The array has no reset, but a write landing on an edge where reset is
    // low is suppressed so that an interrupted stream leaves memory intact.
    assign wr_en = write && wa_ok && reset;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wa] <= d;
        end
    end

    always_comb begin
        rd_word = '0;
        if (ra_ok) begin
            rd_word = mem[ra];
        end
    end

`ifdef SDPM_WRITE_FIRST_EN
    // Bypass the incoming word when the same valid address is written and read.
    always_comb begin
        q_next = rd_word;
        if (write && wa_ok && (wa == ra)) begin
            q_next = d;
        end
    end
`else
    // Read-first: the array read sees the contents from before this edge.
    always_comb begin
        q_next = rd_word;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: tb/tb_simple_dual_port_mem.sv
module tb_simple_dual_port_mem;

    logic        clk;
    logic        reset;
    logic [9:0]  ra, wa;
    logic [31:0] d;
    logic        write;
    logic [31:0] q;

    // Second instance exercises a non-power-of-two depth.
    logic [9:0]  np_ra, np_wa;
    logic [31:0] np_d;
    logic        np_write;
    logic [31:0] np_q;

    int passed;
    int total;

    simple_dual_port_mem #(.MEM_SIZE(1024), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .ra    (ra),
        .wa    (wa),
        .d     (d),
        .write (write),
        .q     (q)
    );

    simple_dual_port_mem #(.MEM_SIZE(1000), .DATA_WIDTH(32)) dut_np (
        .clk   (clk),
        .reset (reset),
        .ra    (np_ra),
        .wa    (np_wa),
        .d     (np_d),
        .write (np_write),
        .q     (np_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        logic [31:0] collide_exp;
`ifdef SDPM_WRITE_FIRST_EN
        collide_exp = 32'hBBBB_BBBB;
`else
        collide_exp = 32'hAAAA_AAAA;
`endif
        passed = 0;
        total  = 0;

        reset = 1'b0; write = 1'b0; ra = '0; wa = '0; d = '0;
        np_write = 1'b0; np_ra = '0; np_wa = '0; np_d = '0;
        #2;
        check("reset_q", q, 32'h0);
        check("reset_np_q", np_q, 32'h0);

        // Writes attempted while reset is low do not disturb q.
        write = 1'b1; wa = 10'd5; d = 32'h1234_5678;
        tick();
        check("reset_hold_q", q, 32'h0);

        // Release reset between edges; first edge performs a normal write.
        reset = 1'b1;
        write = 1'b1; wa = 10'd5; d = 32'hDEAD_BEEF;
        tick();
        write = 1'b0; ra = 10'd5;
        tick();
        check("wr_rd_5", q, 32'hDEAD_BEEF);

        // Independent read and write on the same edge.
        write = 1'b1; wa = 10'd3; d = 32'h1111_1111;
        tick();
        write = 1'b1; wa = 10'd7; d = 32'h2222_2222; ra = 10'd3;
        tick();
        check("indep_rd_3", q, 32'h1111_1111);
        write = 1'b0; ra = 10'd7;
        tick();
        check("indep_rd_7", q, 32'h2222_2222);

        // Same-address collision.
        write = 1'b1; wa = 10'd9; d = 32'hAAAA_AAAA;
        tick();
        write = 1'b1; wa = 10'd9; ra = 10'd9; d = 32'hBBBB_BBBB;
        tick();
        check("collide_q", q, collide_exp);
        write = 1'b0;
        tick();
        check("collide_after", q, 32'hBBBB_BBBB);

        // Back-to-back writes keep the last value.
        write = 1'b1; wa = 10'd12; d = 32'h0000_0001;
        tick();
        d = 32'h0000_0002;
        tick();
        write = 1'b0; ra = 10'd12;
        tick();
        check("b2b_last", q, 32'h0000_0002);

        // Address boundaries.
        write = 1'b1; wa = 10'd0; d = 32'd1;
        tick();
        wa = 10'd1023; d = 32'd2;
        tick();
        write = 1'b0; ra = 10'd0;
        tick();
        check("bound_rd_0", q, 32'd1);
        ra = 10'd1023;
        tick();
        check("bound_rd_1023", q, 32'd2);
        write = 1'b0; wa = 10'd0; d = 32'd3; ra = 10'd0;
        tick();
        tick();
        check("no_write_0", q, 32'd1);
        #3;
        check("q_holds", q, 32'd1);

        // Async reset between edges (q is nonzero here).
        reset = 1'b0;
        #1;
        check("async_clr", q, 32'h0);
        write = 1'b1; wa = 10'd5; d = 32'hCAFE_F00D; ra = 10'd5;
        tick();
        check("rst_low_q", q, 32'h0);
        #2;
        reset = 1'b1; write = 1'b0;
        tick();
        check("retained_5", q, 32'hDEAD_BEEF);
        ra = 10'd9;
        tick();
        check("retained_9", q, 32'hBBBB_BBBB);

        // Non-power-of-two depth: out-of-range write dropped, read returns zero.
        np_write = 1'b1; np_wa = 10'd10; np_d = 32'h0000_0077;
        tick();
        np_wa = 10'd999; np_d = 32'h0000_0999;
        tick();
        np_wa = 10'd1010; np_d = 32'd5;
        tick();
        np_write = 1'b0; np_ra = 10'd10;
        tick();
        check("np_no_alias_10", np_q, 32'h0000_0077);
        np_ra = 10'd999;
        tick();
        check("np_rd_999", np_q, 32'h0000_0999);
        np_ra = 10'd1010;
        tick();
        check("np_rd_oob", np_q, 32'h0);
        np_ra = 10'd1023;
        tick();
        check("np_rd_top", np_q, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
